// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_mem_pkg : MemOp encodings and MEM-stage FSM states.  rev 1.0
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_stage_if : req/gnt/rvalid data-memory bus.  rev 1.0
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align : store lane replication / byte enables, load extract, legality.  rev 1.0
// ---------------------------------------------------------------------------
module mem_align
  import riscv_mem_pkg::*;
(
  input  wire [2:0]   mem_op,
  input  wire [1:0]   addr_lo,
  input  wire [31:0]  store_data,
  input  wire [31:0]  load_word,
  output logic [3:0]  store_be,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        legal
);

  logic [31:0] shifted;

  always_comb begin
    legal = 1'b0;
    case (mem_op)
      MEMOP_B, MEMOP_BU: legal = 1'b1;
      MEMOP_H, MEMOP_HU: legal = ~addr_lo[0];
      MEMOP_W:           legal = (addr_lo == 2'b00);
      default:           legal = 1'b0;
    endcase
  end

  // Size comes from the low two MemOp bits; the sign bit is irrelevant for stores
  always_comb begin
    store_word = store_data;
    store_be   = 4'b1111;
    case (mem_op[1:0])
      2'b00: begin
        store_word = {4{store_data[7:0]}};
        store_be   = 4'b0001 << addr_lo;
      end
      2'b01: begin
        store_word = {2{store_data[15:0]}};
        store_be   = 4'b0011 << addr_lo;
      end
      default: begin
        store_word = store_data;
        store_be   = 4'b1111;
      end
    endcase
  end

  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (mem_op)
      MEMOP_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MEMOP_BU: load_data = {24'b0, shifted[7:0]};
      MEMOP_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MEMOP_HU: load_data = {16'b0, shifted[15:0]};
      default:  load_data = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_stage : MEM pipeline stage with req/gnt/rvalid data bus and MEM/WB register.  rev 1.0
// ---------------------------------------------------------------------------
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  wire         clk,
  input  wire         reset,
  input  wire [2:0]   MemOp_line_in,
  input  wire         MemRead_line_in,
  input  wire         MemWrite_line_in,
  input  wire [31:0]  ReadData2_line_in,
  input  wire [31:0]  ALUResult_line_in,
  input  wire [4:0]   rd_line_in,
  input  wire         RegWrite_line_in,
  input  wire         MemtoReg_line_in,
  mem_access_stage_if.master dmem,
  output logic        mem_stall,
  output logic        mem_fault,
  output logic [31:0] ReadData_line_out,
  output logic [31:0] ALUResult_line_out,
  output logic [4:0]  rd_line_out,
  output logic        RegWrite_line_out,
  output logic        MemtoReg_line_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state, next_state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             is_access, is_store, op_legal;
  logic             start_ok, access_fault, done, load_done, timeout_hit, fault_now;
  logic             req_int, stall_int;
  logic [3:0]       store_be;
  logic [31:0]      store_word, load_ext;

  mem_align u_align (
    .mem_op     (MemOp_line_in),
    .addr_lo    (ALUResult_line_in[1:0]),
    .store_data (ReadData2_line_in),
    .load_word  (dmem.dmem_rdata),
    .store_be   (store_be),
    .store_word (store_word),
    .load_data  (load_ext),
    .legal      (op_legal)
  );

  // A simultaneous read+write request is handled as a store
  assign is_access    = MemRead_line_in | MemWrite_line_in;
  assign is_store     = MemWrite_line_in;
  assign start_ok     = (state == IDLE) & is_access & op_legal;
  assign access_fault = (state == IDLE) & is_access & ~op_legal;
  assign load_done    = (state == WAIT) & dmem.dmem_rvalid;
  assign done         = ((state == REQ) & dmem.dmem_gnt & is_store) | load_done;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                        (tmo_cnt == CNT_LAST) && !done;
  assign fault_now    = access_fault | timeout_hit;

  assign dmem.dmem_addr  = {ALUResult_line_in[31:2], 2'b00};
  assign dmem.dmem_we    = is_store;
  assign dmem.dmem_be    = is_store ? store_be : 4'b1111;
  assign dmem.dmem_wdata = store_word;
  assign dmem.dmem_req   = req_int & reset;
  assign mem_stall       = stall_int & reset;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (!dmem.dmem_gnt)  next_state = REQ;
          else if (!is_store)  next_state = WAIT;
        end
      end
      REQ: begin
        if (timeout_hit)         next_state = IDLE;
        else if (dmem.dmem_gnt)  next_state = is_store ? IDLE : WAIT;
      end
      WAIT: begin
        if (load_done || timeout_hit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_int   = 1'b0;
    stall_int = 1'b0;
    case (state)
      IDLE: begin
        req_int   = start_ok;
        stall_int = start_ok & ~(dmem.dmem_gnt & is_store);
      end
      REQ: begin
        req_int   = 1'b1;
        stall_int = ~done & ~timeout_hit;
      end
      WAIT: stall_int = ~done & ~timeout_hit;
      default: begin
        req_int   = 1'b0;
        stall_int = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || state == IDLE) tmo_cnt <= '0;
    else                         tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // MEM/WB register: a stalled edge becomes a bubble, a faulting edge drops the write
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_fault          <= 1'b0;
      ReadData_line_out  <= '0;
      ALUResult_line_out <= '0;
      rd_line_out        <= '0;
      RegWrite_line_out  <= 1'b0;
      MemtoReg_line_out  <= 1'b0;
    end else begin
      mem_fault <= fault_now;
      if (mem_stall) begin
        RegWrite_line_out <= 1'b0;
        MemtoReg_line_out <= 1'b0;
      end else begin
        ALUResult_line_out <= ALUResult_line_in;
        rd_line_out        <= rd_line_in;
        RegWrite_line_out  <= RegWrite_line_in & ~fault_now;
        MemtoReg_line_out  <= MemtoReg_line_in;
        ReadData_line_out  <= load_done ? load_ext : 32'h0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_access_stage : scoreboard bench for mem_access_stage (TIMEOUT_CYCLES=4).  rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_access_stage;
  import riscv_mem_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic [31:0] rdata;
    logic        fault;
  } wb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  MemOp_in = '0;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0;
  logic [31:0] ReadData2_in = '0, ALUResult_in = '0;
  logic [4:0]  rd_in = '0;
  logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0;
  logic        mem_stall, mem_fault;
  logic [31:0] ReadData_out, ALUResult_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out, MemtoReg_out;

  int  checks = 0;
  int  errors = 0;
  wb_t sb[$];

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .MemOp_line_in      (MemOp_in),
    .MemRead_line_in    (MemRead_in),
    .MemWrite_line_in   (MemWrite_in),
    .ReadData2_line_in  (ReadData2_in),
    .ALUResult_line_in  (ALUResult_in),
    .rd_line_in         (rd_in),
    .RegWrite_line_in   (RegWrite_in),
    .MemtoReg_line_in   (MemtoReg_in),
    .dmem               (bus),
    .mem_stall          (mem_stall),
    .mem_fault          (mem_fault),
    .ReadData_line_out  (ReadData_out),
    .ALUResult_line_out (ALUResult_out),
    .rd_line_out        (rd_out),
    .RegWrite_line_out  (RegWrite_out),
    .MemtoReg_line_out  (MemtoReg_out)
  );

  always #5 clk = ~clk;

  function automatic wb_t observe();
    return {ALUResult_out, rd_out, RegWrite_out, MemtoReg_out, ReadData_out, mem_fault};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  task automatic drive(input logic [2:0] op, input logic rd_en, input logic wr_en,
                       input logic [31:0] rs2, input logic [31:0] alu, input logic [4:0] rd,
                       input logic rw, input logic m2r);
    MemOp_in = op; MemRead_in = rd_en; MemWrite_in = wr_en; ReadData2_in = rs2;
    ALUResult_in = alu; rd_in = rd; RegWrite_in = rw; MemtoReg_in = m2r;
  endtask

  task automatic drive_idle();
    drive(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  // Slave model: grant once req is up from cycle gnt_at (negative = never), rvalid rv_lat later
  task automatic step_access(input int gnt_at, input int rv_lat, output int stalls, output bit hung);
    int grant_k;
    bit fin;
    grant_k = -1; fin = 1'b0; stalls = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      #1;
      bus.dmem_gnt    = bus.dmem_req && (gnt_at >= 0) && (k >= gnt_at) && (grant_k < 0);
      bus.dmem_rvalid = (grant_k >= 0) && (k == grant_k + rv_lat);
      #1;
      if (bus.dmem_gnt) grant_k = k;
      if (mem_stall) stalls++;
      else fin = 1'b1;
      @(posedge clk); #1;
      bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
    end
    hung = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(MEMOP_W, 1'b0, 1'b1, 32'h11, 32'h200, 5'd3, 1'b1, 1'b0);
    @(posedge clk); #2;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL reset_req_stall: got req=%b stall=%b expected 0 0", bus.dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (observe() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", observe());
    end
    drive_idle();
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    int st; bit hung; wb_t e;
    sb.push_back({32'h1234, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0});
    drive(3'b000, 1'b0, 1'b0, 32'hDEAD, 32'h1234, 5'd5, 1'b1, 1'b0);
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL alu_no_req: got %b expected 0", bus.dmem_req); end
    step_access(-1, 0, st, hung);
    e = sb.pop_front();
    checks++;
    if (st != 0 || hung || observe() !== e) begin
      errors++; $display("FAIL alu_wb: got %h stalls=%0d expected %h stalls=0", observe(), st, e);
    end
  endtask

  task automatic test_store();
    int st; bit hung; wb_t e;
    sb.push_back({32'h103, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0});
    drive(MEMOP_B, 1'b0, 1'b1, 32'hAABBCCDD, 32'h103, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata} !==
        {1'b1, 1'b1, 32'h100, 4'b1000, 32'hDDDDDDDD}) begin
      errors++; $display("FAIL sb_bus: got req=%b we=%b addr=%h be=%b wdata=%h expected 1 1 00000100 1000 dddddddd",
                         bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata);
    end
    step_access(0, 0, st, hung);
    e = sb.pop_front();
    checks++;
    if (st != 0 || hung || observe() !== e) begin
      errors++; $display("FAIL sb_wb: got %h stalls=%0d expected %h stalls=0", observe(), st, e);
    end
  endtask

  task automatic test_loads();
    int st; bit hung; wb_t e;
    bus.dmem_rdata = 32'h0080FF00;
    sb.push_back({32'h102, 5'd7, 1'b1, 1'b1, 32'hFFFFFF80, 1'b0});
    drive(MEMOP_B, 1'b1, 1'b0, 32'h0, 32'h102, 5'd7, 1'b1, 1'b1);
    #1;
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_be} !== {1'b1, 1'b0, 4'b1111}) begin
      errors++; $display("FAIL lb_bus: got req=%b we=%b be=%b expected 1 0 1111", bus.dmem_req, bus.dmem_we, bus.dmem_be);
    end
    step_access(0, 2, st, hung);
    e = sb.pop_front();
    checks++;
    if (st != 2 || hung || observe() !== e) begin
      errors++; $display("FAIL lb_wb: got %h stalls=%0d expected %h stalls=2", observe(), st, e);
    end
    sb.push_back({32'h102, 5'd8, 1'b1, 1'b1, 32'h00000080, 1'b0});
    drive(MEMOP_HU, 1'b1, 1'b0, 32'h0, 32'h102, 5'd8, 1'b1, 1'b1);
    step_access(0, 2, st, hung);
    e = sb.pop_front();
    checks++;
    if (st != 2 || hung || observe() !== e) begin
      errors++; $display("FAIL lhu_wb: got %h stalls=%0d expected %h stalls=2", observe(), st, e);
    end
  endtask

  task automatic test_faults();
    int st; bit hung; wb_t e;
    logic [2:0]  ops [3] = '{MEMOP_W, MEMOP_H, 3'b011};
    logic [31:0] adr [3] = '{32'h101, 32'h203, 32'h100};
    for (int i = 0; i < 3; i++) begin
      sb.push_back({adr[i], 5'd4, 1'b0, 1'b1, 32'h0, 1'b1});
      drive(ops[i], 1'b1, 1'b0, 32'h0, adr[i], 5'd4, 1'b1, 1'b1);
      #1;
      checks++;
      if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
        errors++; $display("FAIL fault%0d_req: got req=%b stall=%b expected 0 0", i, bus.dmem_req, mem_stall);
      end
      step_access(0, 1, st, hung);
      e = sb.pop_front();
      checks++;
      if (hung || observe() !== e) begin
        errors++; $display("FAIL fault%0d_wb: got %h expected %h", i, observe(), e);
      end
    end
    drive_idle();
    @(posedge clk); #1;
    checks++;
    if (mem_fault !== 1'b0) begin errors++; $display("FAIL fault_pulse: got %b expected 0", mem_fault); end
  endtask

  task automatic test_timeout();
    int st; bit hung; wb_t e;
    sb.push_back({32'h200, 5'd6, 1'b0, 1'b1, 32'h0, 1'b1});
    drive(MEMOP_W, 1'b1, 1'b0, 32'h0, 32'h200, 5'd6, 1'b1, 1'b1);
    step_access(-1, 0, st, hung);
    e = sb.pop_front();
    checks++;
    if (st != 4 || hung || observe() !== e) begin
      errors++; $display("FAIL timeout_wb: got %h stalls=%0d expected %h stalls=4", observe(), st, e);
    end
    drive_idle();
    #1;
    checks++;
    if (mem_stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got stall=%b req=%b expected 0 0", mem_stall, bus.dmem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_fault !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b expected 0", mem_fault); end
  endtask

  task automatic test_reset_mid();
    drive(MEMOP_W, 1'b1, 1'b0, 32'h0, 32'h300, 5'd9, 1'b1, 1'b1);
    #1; bus.dmem_gnt = bus.dmem_req;
    @(posedge clk); #1; bus.dmem_gnt = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin errors++; $display("FAIL mid_wait_stall: got %b expected 1", mem_stall); end
    reset = 1'b0; #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL mid_reset_req: got req=%b stall=%b expected 0 0", bus.dmem_req, mem_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (observe() !== '0) begin errors++; $display("FAIL mid_reset_out: got %h expected 0", observe()); end
    reset = 1'b1; drive_idle();
    bus.dmem_rdata = 32'hFFFFFFFF; bus.dmem_rvalid = 1'b1; #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL mid_rvalid_stall: got %b expected 0", mem_stall); end
    @(posedge clk); #1; bus.dmem_rvalid = 1'b0;
    checks++;
    if (ReadData_out !== 32'h0 || RegWrite_out !== 1'b0) begin
      errors++; $display("FAIL mid_rvalid_ignored: got rdata=%h rw=%b expected 0 0", ReadData_out, RegWrite_out);
    end
  endtask

  task automatic test_back_to_back();
    int st, exp_st, kind, ga, rl; bit hung; wb_t e;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] adr, word;
    logic [2:0]  lops [5] = '{MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU};
    for (int i = 0; i < 12; i++) begin
      kind = $urandom_range(0, 2);
      ga   = $urandom_range(0, 1);
      rl   = $urandom_range(1, 2);
      word = $urandom;
      bus.dmem_rdata = word;
      op = lops[$urandom_range(0, 4)];
      lo = 2'($urandom_range(0, 3));
      if (op[1:0] == 2'b01) lo[0] = 1'b0;
      if (op[1:0] == 2'b10) lo = 2'b00;
      adr = {18'h0, 12'($urandom), lo};
      if (kind == 0) begin
        exp_st = 0;
        sb.push_back({adr, 5'(i), 1'b1, 1'b0, 32'h0, 1'b0});
        drive(3'b000, 1'b0, 1'b0, word, adr, 5'(i), 1'b1, 1'b0);
      end else if (kind == 1) begin
        exp_st = ga;
        sb.push_back({adr, 5'(i), 1'b0, 1'b0, 32'h0, 1'b0});
        drive(op, 1'b0, 1'b1, word, adr, 5'(i), 1'b0, 1'b0);
      end else begin
        exp_st = ga + rl;
        sb.push_back({adr, 5'(i), 1'b1, 1'b1, ref_load(op, lo, word), 1'b0});
        drive(op, 1'b1, 1'b0, 32'h0, adr, 5'(i), 1'b1, 1'b1);
      end
      step_access(ga, rl, st, hung);
      e = sb.pop_front();
      checks++;
      if (st != exp_st || hung || observe() !== e) begin
        errors++; $display("FAIL b2b_%0d kind%0d op%0d: got %h stalls=%0d expected %h stalls=%0d",
                           i, kind, op, observe(), st, e, exp_st);
      end
    end
    drive_idle();
  endtask

  initial begin
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_store();
    test_loads();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
